// File: rtl/stream_framer_pkg.sv
// Shared types and constants for the stream framer.
// Holds the framing FSM state encoding and default counter width.
`timescale 1ns/1ps
package stream_framer_pkg;
    localparam int LEN_WIDTH_DEF = 16;

    typedef enum logic {
        HUNT,
        PAYLOAD
    } state_t;
endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-Stream output register.
// Accepts a new word whenever the register is empty or being drained.
`timescale 1ns/1ps
module axis_reg_slice #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/stream_framer.sv
// Frames an incoming word stream into header+payload packets.
// Idle words are stripped; stray words are dropped and counted.
`timescale 1ns/1ps
module stream_framer
    import stream_framer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] axis_in_tdata,
    input  logic                  axis_in_tvalid,
    output logic                  axis_in_tready,
    output logic [DATA_WIDTH-1:0] axis_out_tdata,
    output logic                  axis_out_tvalid,
    input  logic                  axis_out_tready,
    output logic                  axis_out_tlast,
    output logic                  axis_out_tuser,
    input  logic [DATA_WIDTH-1:0] idle_word,
    input  logic [DATA_WIDTH-1:0] idle_word_BX0,
    input  logic [DATA_WIDTH-1:0] header,
    input  logic [DATA_WIDTH-1:0] header_BX0,
    input  logic [DATA_WIDTH-1:0] header_mask,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic                  fc_linkReset,
    input  logic                  counter_clear,
    output logic [LEN_WIDTH-1:0]  pkt_count,
    output logic [LEN_WIDTH-1:0]  idle_count,
    output logic [LEN_WIDTH-1:0]  err_count
);
    state_t               state, state_nx;
    logic [LEN_WIDTH-1:0] cnt, cnt_nx;
    logic                 user, user_nx;
    logic                 accept, idle_hit, hdr_hit, bx0_hit;
    logic                 fwd, fwd_last, fwd_user;
    logic                 inc_idle, inc_err, inc_pkt;

    assign accept   = axis_in_tvalid && axis_in_tready;
    assign idle_hit = (axis_in_tdata == idle_word) ||
                      (axis_in_tdata == idle_word_BX0);
    assign bx0_hit  = (axis_in_tdata & header_mask) ==
                      (header_BX0 & header_mask);
    assign hdr_hit  = (axis_in_tdata & header_mask) ==
                      (header & header_mask);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= HUNT;
            cnt   <= '0;
            user  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            user  <= user_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        user_nx  = user;
        fwd      = 1'b0;
        fwd_last = 1'b0;
        fwd_user = user;
        inc_idle = 1'b0;
        inc_err  = 1'b0;
        inc_pkt  = 1'b0;
        if (fc_linkReset) begin
            // Resync drops the beat in flight; only an open packet is an error
            state_nx = HUNT;
            cnt_nx   = '0;
            inc_err  = (state == PAYLOAD);
        end else if (accept) begin
            unique case (state)
                HUNT: begin
                    if (idle_hit) begin
                        inc_idle = 1'b1;
                    end else if (bx0_hit || hdr_hit) begin
                        fwd      = 1'b1;
                        fwd_user = bx0_hit;
                        user_nx  = bx0_hit;
                        if (pkt_len == '0) begin
                            fwd_last = 1'b1;
                            inc_pkt  = 1'b1;
                        end else begin
                            cnt_nx   = pkt_len;
                            state_nx = PAYLOAD;
                        end
                    end else begin
                        inc_err = 1'b1;
                    end
                end
                PAYLOAD: begin
                    fwd    = 1'b1;
                    cnt_nx = cnt - LEN_WIDTH'(1);
                    if (cnt == LEN_WIDTH'(1)) begin
                        fwd_last = 1'b1;
                        inc_pkt  = 1'b1;
                        state_nx = HUNT;
                    end
                end
            endcase
        end
    end

    // Counters saturate; a clear beats any same-cycle increment
    always_ff @(posedge clk) begin
        if (!resetn || counter_clear) begin
            pkt_count  <= '0;
            idle_count <= '0;
            err_count  <= '0;
        end else begin
            if (inc_pkt && pkt_count != '1)
                pkt_count <= pkt_count + LEN_WIDTH'(1);
            if (inc_idle && idle_count != '1)
                idle_count <= idle_count + LEN_WIDTH'(1);
            if (inc_err && err_count != '1)
                err_count <= err_count + LEN_WIDTH'(1);
        end
    end

    axis_reg_slice #(
        .WIDTH(DATA_WIDTH + 2)
    ) u_slice (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   ({fwd_last, fwd_user, axis_in_tdata}),
        .in_valid  (fwd),
        .in_ready  (axis_in_tready),
        .out_data  ({axis_out_tlast, axis_out_tuser, axis_out_tdata}),
        .out_valid (axis_out_tvalid),
        .out_ready (axis_out_tready)
    );
endmodule

// File: tb/tb_stream_framer.sv
// Scoreboard bench for stream_framer with directed vectors.
// Expected output beats are queued at stimulus time and popped by a monitor.
`timescale 1ns/1ps
module tb_stream_framer;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic [DW-1:0] axis_in_tdata;
    logic          axis_in_tvalid;
    logic          axis_in_tready;
    logic [DW-1:0] axis_out_tdata;
    logic          axis_out_tvalid;
    logic          axis_out_tready;
    logic          axis_out_tlast;
    logic          axis_out_tuser;
    logic [DW-1:0] idle_word, idle_word_BX0, header, header_BX0, header_mask;
    logic [LW-1:0] pkt_len;
    logic          fc_linkReset;
    logic          counter_clear;
    logic [LW-1:0] pkt_count, idle_count, err_count;

    always #5 clk = ~clk;

    stream_framer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .axis_in_tdata   (axis_in_tdata),
        .axis_in_tvalid  (axis_in_tvalid),
        .axis_in_tready  (axis_in_tready),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (axis_out_tready),
        .axis_out_tlast  (axis_out_tlast),
        .axis_out_tuser  (axis_out_tuser),
        .idle_word       (idle_word),
        .idle_word_BX0   (idle_word_BX0),
        .header          (header),
        .header_BX0      (header_BX0),
        .header_mask     (header_mask),
        .pkt_len         (pkt_len),
        .fc_linkReset    (fc_linkReset),
        .counter_clear   (counter_clear),
        .pkt_count       (pkt_count),
        .idle_count      (idle_count),
        .err_count       (err_count)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic          u;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [DW-1:0] d, input logic l,
                               input logic u);
        beat_t b;
        b.d = d;
        b.l = l;
        b.u = u;
        exp_q.push_back(b);
    endtask

    always @(negedge clk) begin : monitor
        beat_t e;
        if (resetn && axis_out_tvalid && axis_out_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected none",
                         axis_out_tdata);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 64'(axis_out_tdata), 64'(e.d));
                chk("out_last", 64'(axis_out_tlast), 64'(e.l));
                chk("out_user", 64'(axis_out_tuser), 64'(e.u));
            end
        end
    end

    task automatic send(input logic [DW-1:0] d);
        int n;
        n = 0;
        axis_in_tdata  = d;
        axis_in_tvalid = 1'b1;
        @(negedge clk);
        while (!axis_in_tready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!axis_in_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1");
        end
        @(posedge clk);
        #1;
        axis_in_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn          = 1'b0;
        axis_in_tdata   = '0;
        axis_in_tvalid  = 1'b0;
        axis_out_tready = 1'b1;
        idle_word       = 32'hACCCCCCC;
        idle_word_BX0   = 32'h5CCCCCCC;
        header          = 32'hA0000000;
        header_BX0      = 32'h90000000;
        header_mask     = 32'hF0000000;
        pkt_len         = 16'd3;
        fc_linkReset    = 1'b0;
        counter_clear   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", 64'(axis_in_tready), 64'd1);
        chk("rst_tvalid", 64'(axis_out_tvalid), 64'd0);
        chk("rst_tdata", 64'(axis_out_tdata), 64'd0);
        chk("rst_tlast", 64'(axis_out_tlast), 64'd0);
        chk("rst_tuser", 64'(axis_out_tuser), 64'd0);
        chk("rst_pkt", 64'(pkt_count), 64'd0);
        chk("rst_idle", 64'(idle_count), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_tready", 64'(axis_in_tready), 64'd1);
        @(posedge clk);
        #1;

        // Idle drop, plain header, three payload words
        expect_beat(32'hA0000001, 1'b0, 1'b0);
        expect_beat(32'h00000011, 1'b0, 1'b0);
        expect_beat(32'h00000022, 1'b0, 1'b0);
        expect_beat(32'h00000033, 1'b1, 1'b0);
        send(32'hACCCCCCC);
        send(32'hA0000001);
        send(32'h00000011);
        send(32'h00000022);
        send(32'h00000033);
        drain();
        chk("t1_idle", 64'(idle_count), 64'd1);
        chk("t1_pkt", 64'(pkt_count), 64'd1);
        chk("t1_err", 64'(err_count), 64'd0);

        // Stray word, then BX0 packet whose payload mimics an idle word
        expect_beat(32'h90000005, 1'b0, 1'b1);
        expect_beat(32'h00000044, 1'b0, 1'b1);
        expect_beat(32'hACCCCCCC, 1'b0, 1'b1);
        expect_beat(32'h00000066, 1'b1, 1'b1);
        send(32'h00000077);
        send(32'h90000005);
        send(32'h00000044);
        send(32'hACCCCCCC);
        send(32'h00000066);
        drain();
        chk("t2_err", 64'(err_count), 64'd1);
        chk("t2_pkt", 64'(pkt_count), 64'd2);
        chk("t2_idle", 64'(idle_count), 64'd1);

        // Zero-length packets back to back
        pkt_len = 16'd0;
        expect_beat(32'hA0000000, 1'b1, 1'b0);
        expect_beat(32'hA0000000, 1'b1, 1'b0);
        send(32'hA0000000);
        send(32'hA0000000);
        drain();
        chk("t3_pkt", 64'(pkt_count), 64'd4);

        // Downstream stall for five cycles mid-packet
        pkt_len = 16'd3;
        axis_out_tready = 1'b0;
        expect_beat(32'hA0000002, 1'b0, 1'b0);
        expect_beat(32'h00000111, 1'b0, 1'b0);
        expect_beat(32'h00000222, 1'b0, 1'b0);
        expect_beat(32'h00000333, 1'b1, 1'b0);
        send(32'hA0000002);
        axis_in_tdata  = 32'h00000111;
        axis_in_tvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_tready", 64'(axis_in_tready), 64'd0);
            chk("stall_tvalid", 64'(axis_out_tvalid), 64'd1);
            chk("stall_tdata", 64'(axis_out_tdata), 64'hA0000002);
        end
        @(posedge clk);
        #1;
        axis_out_tready = 1'b1;
        send(32'h00000111);
        send(32'h00000222);
        send(32'h00000333);
        drain();
        chk("t4_pkt", 64'(pkt_count), 64'd5);

        // Link reset after two of four payload words
        pkt_len = 16'd4;
        expect_beat(32'hA0000003, 1'b0, 1'b0);
        expect_beat(32'h00000001, 1'b0, 1'b0);
        expect_beat(32'h00000002, 1'b0, 1'b0);
        send(32'hA0000003);
        send(32'h00000001);
        send(32'h00000002);
        fc_linkReset   = 1'b1;
        axis_in_tdata  = 32'h00000003;
        axis_in_tvalid = 1'b1;
        @(posedge clk);
        #1;
        fc_linkReset   = 1'b0;
        axis_in_tvalid = 1'b0;
        send(32'hACCCCCCC);
        expect_beat(32'hA0000004, 1'b0, 1'b0);
        expect_beat(32'h00000005, 1'b0, 1'b0);
        expect_beat(32'h00000006, 1'b0, 1'b0);
        expect_beat(32'h00000007, 1'b0, 1'b0);
        expect_beat(32'h00000008, 1'b1, 1'b0);
        send(32'hA0000004);
        send(32'h00000005);
        send(32'h00000006);
        send(32'h00000007);
        send(32'h00000008);
        drain();
        chk("t5_err", 64'(err_count), 64'd2);
        chk("t5_idle", 64'(idle_count), 64'd2);
        chk("t5_pkt", 64'(pkt_count), 64'd6);

        // Idle counter saturation, then clear against a same-cycle idle
        axis_in_tdata  = 32'hACCCCCCC;
        axis_in_tvalid = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        @(negedge clk);
        chk("sat_idle", 64'(idle_count), 64'hFFFF);
        @(posedge clk);
        #1;
        chk("sat_idle_hold", 64'(idle_count), 64'hFFFF);
        counter_clear = 1'b1;
        @(posedge clk);
        #1;
        counter_clear  = 1'b0;
        axis_in_tvalid = 1'b0;
        @(negedge clk);
        chk("clr_idle", 64'(idle_count), 64'd0);
        chk("clr_pkt", 64'(pkt_count), 64'd0);
        chk("clr_err", 64'(err_count), 64'd0);
        chk("final_q", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_framer.md
STREAM_FRAMER -- requirements
Module: stream_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of stream words and all pattern inputs.
REQ-002 Parameter LEN_WIDTH, default 16, width of pkt_len, payload counter and statistics counters.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 axis_in_tdata / axis_in_tvalid / axis_in_tready  in / in / out  DATA_WIDTH / 1 / 1  input stream from the data mux output.
REQ-006 axis_out_tdata / axis_out_tvalid / axis_out_tready  out / out / in  DATA_WIDTH / 1 / 1  framed output stream.
REQ-007 axis_out_tlast  out  1  marks the final word of a packet.
REQ-008 axis_out_tuser  out  1  set on every word of a packet whose header matched header_BX0.
REQ-009 idle_word, idle_word_BX0, header, header_BX0, header_mask  in  DATA_WIDTH each  static configuration patterns.
REQ-010 pkt_len  in  LEN_WIDTH  number of payload words after each header.
REQ-011 fc_linkReset  in  1  fast-control resynchronisation pulse.
REQ-012 counter_clear  in  1  single-cycle pulse zeroing all statistics counters.
REQ-013 pkt_count, idle_count, err_count  out  LEN_WIDTH each  statistics counters.

Function
REQ-014 A beat SHALL be accepted when axis_in_tvalid and axis_in_tready are both high.
REQ-015 axis_in_tready SHALL equal (not axis_out_tvalid) or axis_out_tready; a single output register gives 1-cycle latency from acceptance to axis_out_tvalid.
REQ-016 axis_out_tdata/tlast/tuser SHALL hold stable while axis_out_tvalid=1 and axis_out_tready=0.
REQ-017 FSM states SHALL be HUNT and PAYLOAD.
REQ-018 In HUNT, an accepted word equal to idle_word or idle_word_BX0 SHALL be dropped and increment idle_count.
REQ-019 In HUNT, a word with (word & header_mask) == (header_BX0 & header_mask) SHALL be forwarded with tuser=1; else matching header under the mask, tuser=0; BX0 match has priority.
REQ-020 On header forward: pkt_len=0 -> tlast=1, increment pkt_count, remain in HUNT; else load payload counter with pkt_len, tlast=0, go to PAYLOAD.
REQ-021 In HUNT, any other accepted word SHALL be dropped and increment err_count.
REQ-022 In PAYLOAD, every accepted word SHALL be forwarded unchanged, with the packet's tuser, and decrement the counter; header/idle patterns get no special treatment.
REQ-023 The word that decrements the counter to 0 SHALL carry tlast=1, increment pkt_count, and return the FSM to HUNT.
REQ-024 fc_linkReset=1 SHALL force HUNT on the next cycle and discard any beat accepted that cycle; a pending output word is still delivered.
REQ-025 fc_linkReset in PAYLOAD SHALL increment err_count once (aborted packet, no tlast emitted).
REQ-026 All counters SHALL saturate at all-ones, never wrap.
REQ-027 counter_clear SHALL zero counters next cycle and take priority over a same-cycle increment.

Reset
REQ-028 With resetn=0 at a clk edge: FSM=HUNT, payload counter=0, axis_out_tvalid=0, axis_out_tlast=0, axis_out_tuser=0, axis_out_tdata=0, all statistics counters=0.
REQ-029 axis_in_tready SHALL be 1 during and immediately after reset.
REQ-030 Reset mid-packet SHALL drop the partial packet without emitting tlast or counting an error.

Structure
REQ-031 Package stream_framer_pkg SHALL hold the FSM state enum and the default LEN_WIDTH constant.
REQ-032 The output register with its tready logic SHALL be a sub-module named axis_reg_slice.

Verification
REQ-033 pkt_len=3, header_mask=F0000000; stream ACCCCCCC, A0000001, 11, 22, 33 -> out A0000001,11,22,33 with tlast on 33, tuser=0, idle_count=1, pkt_count=1.
REQ-034 Header 90000005 -> all packet words tuser=1; a 00000077 in HUNT -> dropped, err_count=1.
REQ-035 pkt_len=0, two headers A0000000 back-to-back -> two single-word packets, each tlast=1, pkt_count=2.
REQ-036 axis_out_tready low 5 cycles mid-packet -> axis_in_tready low, output word stable, no loss or duplication.
REQ-037 fc_linkReset after 2 of 4 payload words -> FSM HUNT, err_count=1, next header starts a fresh packet.
REQ-038 Preload idle_count to FFFF via 65535+ idles -> stays FFFF; counter_clear with simultaneous idle -> 0.
